// File: rtl/rx_word_assembler.sv
// rx_word_assembler
//   Packs a stream of UART bytes (RxData/RxDone) into BYTES-wide words and
//   queues them in a small FIFO for a ready/valid consumer.
//
//   Optional feature macro: RXWORD_TIMEOUT_EN
//     defined   -> inter-byte timeout discards a stale partial word
//     undefined -> COLLECT waits forever, timeout_err tied to 0
//
//   Ports
//     clk          system clock, rising edge
//     reset        asynchronous, active-low reset
//     RxData[7:0]  received byte, qualified by RxDone
//     RxDone       single-cycle byte strobe
//     word_data    FIFO head word (combinational from storage)
//     word_valid   FIFO not empty
//     word_ready   consumer accepts head word on valid&ready
//     fifo_count   number of stored words
//     overflow     sticky: completed word dropped on a full FIFO
//     timeout_err  sticky: partial word discarded by timeout
//     clr_err      pulse clearing both sticky flags (set wins)
module rx_word_assembler #(
  parameter int BYTES       = 2,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    RxData,
  input  logic                          RxDone,
  output logic [8*BYTES-1:0]            word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_err,
  input  logic                          clr_err
);

  localparam int W  = 8 * BYTES;
  localparam int KW = $clog2(BYTES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [KW-1:0]                k_q, k_d, slot;
  logic [W-1:0]                 part_q, part_d;
  logic [FIFO_DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]                wptr_q, rptr_q;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic                         push, pop, full, push_ok, ovf_set;
  logic                         tmo_fire;

`ifdef RXWORD_TIMEOUT_EN
  // Counts idle cycles while a partial word is held. Fires on the cycle the
  // count would reach TIMEOUT_CYC; an RxDone on that cycle wins instead.
  logic [19:0] tmo_q, tmo_d;
  logic        tmo_err_q, tmo_err_d;

  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if (state_q == S_COLLECT && !RxDone) begin
      if (tmo_q + 20'd1 == 20'(TIMEOUT_CYC)) tmo_fire = 1'b1;
      else                                    tmo_d    = tmo_q + 20'd1;
    end
  end

  assign tmo_err_d = tmo_fire | (tmo_err_q & ~clr_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Byte slot for the current index; the partial register is never cleared,
  // every slot is rewritten before the word is pushed.
  assign slot = (MSB_FIRST != 0) ? (KW'(BYTES - 1) - k_q) : k_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    part_d  = part_q;
    push    = 1'b0;
    if (RxDone) begin
      for (int b = 0; b < BYTES; b++)
        if (slot == KW'(b)) part_d[b*8 +: 8] = RxData;
      if (k_q == KW'(BYTES - 1)) begin
        push    = 1'b1;
        k_d     = '0;
        state_d = S_IDLE;
      end else begin
        k_d     = k_q + KW'(1);
        state_d = S_COLLECT;
      end
    end else if (tmo_fire) begin
      k_d     = '0;
      state_d = S_IDLE;
    end
  end

  assign pop     = (cnt_q != '0) && word_ready;
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  // A full FIFO still takes the word if the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_d   = ovf_set | (ovf_q & ~clr_err);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      part_q  <= '0;
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (push_ok) begin
        mem_q[wptr_q] <= part_d;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
    end
  end

  assign word_data  = mem_q[rptr_q];
  assign word_valid = (cnt_q != '0);
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule
